// File: rtl/deserializer.sv
// Serial-to-parallel stage that feeds priority_encoder.
// Collects 1-bit samples qualified by data_val_i into a WIDTH-bit word and
// emits that word with a one-cycle data_val_o pulse. flush_i releases a
// partially filled word, zero-padded, together with its bit count.
module deserializer #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] data_cnt_o,
  output logic             data_val_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH - 1);

  // Bits are written straight into their final position, so the word needs
  // no shifting on emit and unfilled positions stay at zero.
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] pos;
  logic [WIDTH-1:0] word_acc;
  logic [CNT_W-1:0] cnt_acc;
  logic             emit;

  // Fold in this cycle's bit (if any) and decide whether a word leaves now.
  // NOTE: every always_comb output gets a default first so no path can hold
  // an old value, which would infer a latch.
  always_comb begin
    pos      = '0;
    word_acc = word_q;
    cnt_acc  = cnt_q;
    emit     = 1'b0;

    // Bit k of a word lands at WIDTH-1-k (MSB first) or at k (LSB first).
    if (MSB_FIRST) begin
      pos = LAST_C - cnt_q;
    end else begin
      pos = cnt_q;
    end

    if (data_val_i) begin
      word_acc = word_q | (WIDTH'(data_i) << pos);
      cnt_acc  = cnt_q + CNT_W'(1);
    end

    // A full word always leaves; a flush releases whatever is held,
    // including a bit accepted in the same cycle. An empty flush is ignored.
    emit = (cnt_acc == WIDTH_C) || (flush_i && (cnt_acc != '0));
  end

  // Collection state and registered outputs; srst_i overrides everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      word_q     <= '0;
      cnt_q      <= '0;
      data_o     <= '0;
      data_cnt_o <= '0;
      data_val_o <= 1'b0;
      busy_o     <= 1'b0;
    end else if (emit) begin
      // Emitting clears the collector so the next accepted bit is bit 0.
      word_q     <= '0;
      cnt_q      <= '0;
      data_o     <= word_acc;
      data_cnt_o <= cnt_acc;
      data_val_o <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      // data_o / data_cnt_o keep the last emitted word between pulses.
      word_q     <= word_acc;
      cnt_q      <= cnt_acc;
      data_val_o <= 1'b0;
      busy_o     <= (cnt_acc != '0);
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer (WIDTH=5). Two instances, MSB_FIRST=1 and 0, share
// one stimulus stream. Directed vectors come from a table of per-cycle
// records; a random stream is then checked against a queue-based model.
module tb_deserializer;

  localparam int W  = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst = 1'b1;
  logic din  = 1'b0;
  logic dval = 1'b0;
  logic flush = 1'b0;

  logic [W-1:0]  m_data, l_data;
  logic [CW-1:0] m_cnt, l_cnt;
  logic          m_val, l_val, m_busy, l_busy;

  deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval),
    .flush_i(flush), .data_o(m_data), .data_cnt_o(m_cnt),
    .data_val_o(m_val), .busy_o(m_busy)
  );

  deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval),
    .flush_i(flush), .data_o(l_data), .data_cnt_o(l_cnt),
    .data_val_o(l_val), .busy_o(l_busy)
  );

  // One clock cycle: inputs, then outputs expected just after the edge.
  // exp_lsb is the data_o expected from the MSB_FIRST=0 instance.
  typedef struct {
    logic          srst, d, v, f;
    logic [W-1:0]  exp_msb;
    logic [W-1:0]  exp_lsb;
    logic [CW-1:0] exp_cnt;
    logic          exp_val, exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic v,
                     input logic f, input logic [W-1:0] em,
                     input logic [W-1:0] el, input logic [CW-1:0] ec,
                     input logic ev, input logic eb);
    vec_t r;
    r.srst = s; r.d = d; r.v = v; r.f = f;
    r.exp_msb = em; r.exp_lsb = el; r.exp_cnt = ec;
    r.exp_val = ev; r.exp_busy = eb;
    vecs.push_back(r);
  endtask

  task automatic drive_cycle(input logic s, input logic d, input logic v,
                             input logic f);
    srst = s; din = d; dval = v; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag, input logic [W-1:0] em,
                             input logic [W-1:0] el, input logic [CW-1:0] ec,
                             input logic ev, input logic eb);
    check({tag, " msb.data"}, 32'(m_data), 32'(em));
    check({tag, " lsb.data"}, 32'(l_data), 32'(el));
    check({tag, " msb.cnt"},  32'(m_cnt),  32'(ec));
    check({tag, " lsb.cnt"},  32'(l_cnt),  32'(ec));
    check({tag, " msb.val"},  32'(m_val),  32'(ev));
    check({tag, " lsb.val"},  32'(l_val),  32'(ev));
    check({tag, " msb.busy"}, 32'(m_busy), 32'(eb));
    check({tag, " lsb.busy"}, 32'(l_busy), 32'(eb));
  endtask

  // Reference model state for the random stream.
  bit            q[$];
  logic [W-1:0]  md_msb, md_lsb;
  logic [CW-1:0] md_cnt;
  logic          md_val, md_busy;

  task automatic model_step(input logic s, input logic d, input logic v,
                            input logic f);
    if (s) begin
      q.delete();
      md_msb = '0; md_lsb = '0; md_cnt = '0; md_val = 1'b0; md_busy = 1'b0;
    end else begin
      if (v) q.push_back(d);
      if (q.size() == W || (f && q.size() > 0)) begin
        md_msb = '0;
        md_lsb = '0;
        foreach (q[k]) begin
          md_msb[W-1-k] = q[k];
          md_lsb[k]     = q[k];
        end
        md_cnt = CW'(q.size());
        md_val = 1'b1;
        q.delete();
      end else begin
        md_val = 1'b0;
      end
      md_busy = (q.size() != 0);
    end
  endtask

  initial begin
    //   srst d  v  f   exp_msb   exp_lsb   cnt  val busy
    // Reset with every other input active: srst wins.
    add(1, 1, 1, 1, 5'b00000, 5'b00000, 0, 0, 0);
    // 1,0,1,1,0 back to back.
    add(0, 1, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 1, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 1, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 0, 1, 0, 5'b10110, 5'b01101, 5, 1, 0);
    add(0, 1, 0, 0, 5'b10110, 5'b01101, 5, 0, 0);
    // Same bits, two idle cycles (data_i toggling, ignored) after bit 2.
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 0, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 0, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 0, 0, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 0, 1, 0, 5'b10110, 5'b01101, 5, 1, 0);
    // Ten bits back to back: 1,1,1,1,1 | 0,0,0,0,1.
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 5, 0, 1);
    add(0, 1, 1, 0, 5'b11111, 5'b11111, 5, 1, 0);
    add(0, 0, 1, 0, 5'b11111, 5'b11111, 5, 0, 1);
    add(0, 0, 1, 0, 5'b11111, 5'b11111, 5, 0, 1);
    add(0, 0, 1, 0, 5'b11111, 5'b11111, 5, 0, 1);
    add(0, 0, 1, 0, 5'b11111, 5'b11111, 5, 0, 1);
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 1, 0);
    // 1,1 then flush alone; then flush with nothing held.
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 0, 0, 1, 5'b11000, 5'b00011, 2, 1, 0);
    add(0, 0, 0, 1, 5'b11000, 5'b00011, 2, 0, 0);
    add(0, 0, 0, 0, 5'b11000, 5'b00011, 2, 0, 0);
    // 1,0,1 then flush together with bit 1: four bits emitted.
    add(0, 1, 1, 0, 5'b11000, 5'b00011, 2, 0, 1);
    add(0, 0, 1, 0, 5'b11000, 5'b00011, 2, 0, 1);
    add(0, 1, 1, 0, 5'b11000, 5'b00011, 2, 0, 1);
    add(0, 1, 1, 1, 5'b10110, 5'b01101, 4, 1, 0);
    // 1,1,1 then reset mid-word, then 0,0,0,0,1.
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 4, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 4, 0, 1);
    add(0, 1, 1, 0, 5'b10110, 5'b01101, 4, 0, 1);
    add(1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    add(0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1);
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 1, 0);
    // 0,1,0,1 then flush with the fifth bit: an ordinary full word.
    add(0, 0, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 0, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 1, 1, 0, 5'b00001, 5'b10000, 5, 0, 1);
    add(0, 1, 1, 1, 5'b01011, 5'b11010, 5, 1, 0);
    add(0, 0, 0, 0, 5'b01011, 5'b11010, 5, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].srst, vecs[i].d, vecs[i].v, vecs[i].f);
      compare_all($sformatf("vec%0d", i), vecs[i].exp_msb, vecs[i].exp_lsb,
                  vecs[i].exp_cnt, vecs[i].exp_val, vecs[i].exp_busy);
    end

    // Random stream; the first cycle is a reset to align the model.
    for (int i = 0; i < 600; i++) begin
      logic s, d, v, f;
      s = (i == 0) || ($urandom_range(0, 99) < 2);
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 99) < 12);
      model_step(s, d, v, f);
      drive_cycle(s, d, v, f);
      compare_all($sformatf("rnd%0d", i), md_msb, md_lsb, md_cnt, md_val,
                  md_busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
